// File: rtl/sdb_pkg.sv
// sdb_pkg: shared defaults and reference arithmetic for the carry-select adder datapath
package sdb_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_BLOCK = 4;
    function automatic logic [DEF_WIDTH:0] ref_add(
        input logic [DEF_WIDTH-1:0] a,
        input logic [DEF_WIDTH-1:0] b,
        input logic                 c_in
    );
        return {1'b0, a} + {1'b0, b} + {{DEF_WIDTH{1'b0}}, c_in};
    endfunction
endpackage

// File: rtl/sdb_select_block.sv
// sdb_select_block: dual ripple over one sub-block, selected by the incoming block carry
module sdb_select_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] g,
    input  logic [BLOCK-1:0] p,
    input  logic             c_in,
    output logic [BLOCK-1:0] sum,
    output logic             c_out
);
    logic [BLOCK:0]   c0, c1;
    logic [BLOCK-1:0] sum0, sum1;
    logic             cout0, cout1;
    always_comb begin
        c0 = '0;
        c1 = '0;
        c1[0] = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            c0[i+1] = g[i] | (p[i] & c0[i]);
            c1[i+1] = g[i] | (p[i] & c1[i]);
        end
    end
    assign sum0  = p ^ c0[BLOCK-1:0];
    assign sum1  = p ^ c1[BLOCK-1:0];
    assign cout0 = c0[BLOCK];
    assign cout1 = c1[BLOCK];
    assign sum   = c_in ? sum1 : sum0;
    assign c_out = c_in ? cout1 : cout0;
endmodule

// File: rtl/sdb_inner_adder.sv
// sdb_inner_adder: registered carry-select adder segment with propagate-vector consistency flag
module sdb_inner_adder
    import sdb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             p_err
);
    localparam int NB = WIDTH / BLOCK;
    logic [WIDTH-1:0] g, s_d, s_q;
    logic [NB:0]      bc;
    logic             valid_q, c_d, c_q, err_d, err_q;
    assign g     = a & b;
    assign bc[0] = c_in;
    for (genvar k = 0; k < NB; k++) begin : g_blk
        sdb_select_block #(.BLOCK(BLOCK)) u_blk (
            .g    (g[k*BLOCK +: BLOCK]),
            .p    (p[k*BLOCK +: BLOCK]),
            .c_in (bc[k]),
            .sum  (s_d[k*BLOCK +: BLOCK]),
            .c_out(bc[k+1])
        );
    end
    assign c_d   = bc[NB];
    // the sum uses the supplied p as-is; a bad p is only flagged, never corrected
    assign err_d = p != (a ^ b);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                s_q   <= s_d;
                c_q   <= c_d;
                err_q <= err_d;
            end
        end
    end
    assign out_valid = valid_q;
    assign s         = s_q;
    assign c_out     = c_q;
    assign p_err     = err_q;
endmodule

// File: tb/tb_sdb_inner_adder.sv
// tb_sdb_inner_adder: scoreboard bench for the registered carry-select adder segment
module tb_sdb_inner_adder;
    typedef struct packed {
        logic       e;
        logic       c;
        logic [7:0] s;
    } exp_t;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] a = '0, b = '0, p = '0;
    logic       c_in = 1'b0;
    logic       out_valid, c_out, p_err, out_valid2, c_out2, p_err2;
    logic [7:0] s, s2;
    logic       exp_v;
    exp_t       q[$];
    exp_t       last = '0;
    int         n_cmp = 0;
    int         n_err = 0;
    always #5 clk = ~clk;
    sdb_inner_adder #(.WIDTH(8), .BLOCK(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .p(p), .c_in(c_in),
        .out_valid(out_valid), .s(s), .c_out(c_out), .p_err(p_err)
    );
    sdb_inner_adder #(.WIDTH(8), .BLOCK(4)) u_twin (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .p(p), .c_in(c_in),
        .out_valid(out_valid2), .s(s2), .c_out(c_out2), .p_err(p_err2)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    always @(posedge clk or posedge rst) exp_v <= rst ? 1'b0 : in_valid;
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", {31'd0, out_valid}, {31'd0, exp_v});
            chk("twin", {21'd0, out_valid2, c_out2, p_err2, s2}, {21'd0, out_valid, c_out, p_err, s});
            if (exp_v) begin
                if (q.size() == 0) chk("underflow", 32'd1, 32'd0);
                else last = q.pop_front();
            end
            chk(exp_v ? "sum" : "hold_sum", {24'd0, s}, {24'd0, last.s});
            chk(exp_v ? "cout" : "hold_cout", {31'd0, c_out}, {31'd0, last.c});
            chk(exp_v ? "perr" : "hold_perr", {31'd0, p_err}, {31'd0, last.e});
        end
    end
    task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] tp, input logic tc, input exp_t e);
        @(posedge clk);
        #1;
        in_valid = v;
        a = ta;
        b = tb;
        p = tp;
        c_in = tc;
        if (v) q.push_back(e);
    endtask
    task automatic drive_rand(input logic v);
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] sum;
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom_range(0, 1));
        sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
        drive(v, ra, rb, ra ^ rb, rc, {1'b0, sum[8], sum[7:0]});
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 8'hFF, 8'h01, 8'hFE, 1'b0, {1'b0, 1'b1, 8'h00});
        drive(1'b1, 8'h5A, 8'h3C, 8'h66, 1'b1, {1'b0, 1'b0, 8'h97});
        drive(1'b1, 8'h5A, 8'h3C, 8'h66, 1'b0, {1'b0, 1'b0, 8'h96});
        drive(1'b0, 8'h12, 8'h34, 8'h00, 1'b1, '0);
        drive(1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, '0);
        drive(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1, {1'b0, 1'b1, 8'hFF});
        drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, {1'b0, 1'b0, 8'h00});
        drive(1'b1, 8'h0F, 8'hF0, 8'h00, 1'b0, {1'b1, 1'b0, 8'h00});
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, '0);
        for (int i = 0; i < 1000; i++) drive_rand(1'($urandom_range(0, 1)));
        drive_rand(1'b1);
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        a = 8'hC3;
        b = 8'h3C;
        p = 8'hFF;
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {24'd0, s}, 32'd0);
        chk("rst_cout", {31'd0, c_out}, 32'd0);
        chk("rst_perr", {31'd0, p_err}, 32'd0);
        q.delete();
        last = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, '0);
        drive(1'b1, 8'h80, 8'h80, 8'h00, 1'b1, {1'b0, 1'b1, 8'h01});
        drive(1'b1, 8'h01, 8'h02, 8'h00, 1'b0, {1'b1, 1'b0, 8'h00});
        drive(1'b1, 8'h0F, 8'h01, 8'h0E, 1'b0, {1'b0, 1'b0, 8'h10});
        drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("drain", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdb_inner_adder.md
Name: sdb_inner_adder

Overview:
- Registered carry-select adder segment for the carry-select adder datapath.
- Takes operands a, b, a precomputed propagate vector p (= a ^ b) and a carry-in.
- Produces a WIDTH-bit sum and a carry-out, both registered.
- Internally split into BLOCK-bit sub-blocks; each sub-block precomputes results for carry 0 and carry 1, and the incoming block carry selects between them.

Parameters:
- WIDTH, 8, operand/sum width in bits; must be a multiple of BLOCK and at least 1.
- BLOCK, 4, carry-select sub-block width in bits; 1 <= BLOCK <= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- p  input  WIDTH  propagate vector, supplied by upstream as a ^ b.
- c_in  input  1  carry-in.
- out_valid  output  1  s/c_out/p_err hold a fresh result.
- s  output  WIDTH  registered sum bits [WIDTH-1:0] of a + b + c_in.
- c_out  output  1  registered carry-out (bit WIDTH of a + b + c_in).
- p_err  output  1  registered flag: p != (a ^ b) for the captured operands.

Behaviour:
- Reset: while rst=1, out_valid=0, s=0, c_out=0, p_err=0, asynchronously. Release takes effect on the next clk edge.
- Arithmetic:
  - Generate g[i] = a[i] & b[i]. Sum bit s[i] = p[i] ^ carry[i].
  - Carry[i+1] = g[i] | (p[i] & carry[i]); carry[0] = c_in.
  - When p == a^b, {c_out, s} == a + b + c_in exactly: WIDTH+1-bit result, unsigned, no overflow flag.
- Carry-select structure:
  - Sub-block k covers bits [k*BLOCK +: BLOCK].
  - Each sub-block computes (sum0, cout0) assuming carry-in 0 and (sum1, cout1) assuming carry-in 1, by ripple inside the block.
  - The true block carry-in selects between them. Block 0 may use c_in directly.
  - The final block's selected carry is c_out.
- Latency: exactly 1 cycle. On a rising clk edge with in_valid=1, capture the result.
  - out_valid=1 next cycle.
  - s, c_out and p_err update together.
- in_valid=0 on an edge: out_valid goes 0; s, c_out and p_err hold their previous values.
- Throughput: one operation per cycle, no backpressure, no stall.
- p mismatch: when p != a^b, s and c_out follow the formulas above using the supplied p (no correction), and p_err=1 for that result.
- Reset mid-operation: any in-flight result is discarded; out_valid=0 until a new in_valid is captured after release.
- Determinism: two instances with identical inputs produce bit-identical outputs every cycle.

Decomposition:
- Shared package sdb_pkg holds:
  - default WIDTH/BLOCK constants;
  - a function computing the reference {carry, sum} for benches.
- One natural sub-module: sdb_select_block. It is a BLOCK-bit dual ripple that outputs sum0, sum1, cout0 and cout1, plus a select mux driven by the block carry-in.
- The top level generates WIDTH/BLOCK instances, chains the selected carries, and registers outputs.

Test Plan:
- Reset: assert rst mid-stream with in_valid=1 -> out_valid=0, s=0x00, c_out=0, p_err=0 immediately. No output until one cycle after the first post-reset in_valid.
- Wrap: a=0xFF, b=0x01, p=0xFE, c_in=0 -> next cycle s=0x00, c_out=1, p_err=0.
- Carry-in propagation: a=0x5A, b=0x3C, p=0x66, c_in=1 -> s=0x97, c_out=0. Same operands with c_in=0 -> s=0x96, c_out=0.
- Max: a=0xFF, b=0xFF, p=0x00, c_in=1 -> s=0xFF, c_out=1. Zero: all inputs 0 -> s=0x00, c_out=0.
- p mismatch: a=0x0F, b=0xF0, p=0x00, c_in=0 -> p_err=1, s=0x00, c_out=0.
- Streaming: 1000 random back-to-back operations with p=a^b, in_valid toggled randomly:
  - each result matches the reference one cycle later;
  - output holds while in_valid=0;
  - two parallel instances always agree.
